energy_sample_scheduler: RTL and testbench

Round-robin scheduler that shares one power-converter front end and one data-collector input between N_CH energy sources (solar, wind, battery, ...).
- Per transaction: grants one requesting source, drives the converter channel select, waits a settle time, pulses a conversion start, then waits for done or timeout.
- Forwards the result, tagged with its channel, to the data collector over a valid/ready handshake.
- Sits between the source request logic and the power_converter/data_collector pair.

---
 rtl/energy_sample_scheduler_pkg.sv | 21 ++
 rtl/energy_sample_scheduler_rr_priority_pick.sv | 29 ++
 rtl/energy_sample_scheduler.sv | 137 +++++++++++++
 tb/tb_energy_sample_scheduler.sv | 353 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/energy_sample_scheduler_pkg.sv
// Shared types and defaults for the energy sample scheduler.
// Holds the FSM encoding, channel-index width helper and timing defaults.
package energy_sample_scheduler_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SETTLE = 3'd1,
    S_START  = 3'd2,
    S_WAIT   = 3'd3,
    S_EMIT   = 3'd4
  } state_t;

  localparam int SETTLE_DEF  = 2;
  localparam int TIMEOUT_DEF = 15;

  // Channel index width; never narrower than one bit.
  function automatic int ch_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/energy_sample_scheduler_rr_priority_pick.sv
// Combinational round-robin pick: first set request at or above i_ptr, wrapping.
// Distance 0 from the pointer has the highest priority.
module rr_priority_pick #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_ptr,
  output logic [IW-1:0] o_idx,
  output logic          o_found
);

  always_comb begin
    int k;
    k       = 0;
    o_idx   = '0;
    o_found = 1'b0;
    // Walk from the farthest candidate back to the pointer so the nearest one wins.
    for (int i = N - 1; i >= 0; i--) begin
      k = int'(i_ptr) + i;
      if (k >= N) k = k - N;
      if (i_req[k]) begin
        o_idx   = IW'(k);
        o_found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/energy_sample_scheduler.sv
// Round-robin scheduler sharing one converter front end and one collector input
// between N_CH sources: grant, settle, start, wait for done/timeout, emit result.
module energy_sample_scheduler
  import energy_sample_scheduler_pkg::*;
#(
  parameter  int N_CH    = 4,
  parameter  int DW      = 8,
  parameter  int SETTLE  = SETTLE_DEF,
  parameter  int TIMEOUT = TIMEOUT_DEF,
  localparam int CHW     = ch_width(N_CH)
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_en,
  input  logic [N_CH-1:0] i_req,
  output logic [N_CH-1:0] o_grant,
  output logic [CHW-1:0]  o_conv_ch,
  output logic            o_conv_start,
  input  logic            i_conv_done,
  input  logic [DW-1:0]   i_conv_data,
  output logic            o_out_valid,
  input  logic            i_out_ready,
  output logic [DW-1:0]   o_out_data,
  output logic [CHW-1:0]  o_out_ch,
  output logic            o_out_err,
  output logic            o_busy,
  output logic [7:0]      o_timeout_cnt,
  output logic [2:0]      o_state
);

  if (N_CH < 2 || N_CH > 8) begin : g_bad_nch
    $error("energy_sample_scheduler: N_CH must be 2..8");
  end
  if (SETTLE < 1 || SETTLE > 15) begin : g_bad_settle
    $error("energy_sample_scheduler: SETTLE must be 1..15");
  end
  if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
    $error("energy_sample_scheduler: TIMEOUT must be 1..255");
  end

  state_t            r_state;
  state_t            w_next_state;
  logic [CHW-1:0]    r_ptr;
  logic [CHW-1:0]    r_ch;
  logic [N_CH-1:0]   r_grant;
  logic [7:0]        r_cnt;
  logic [DW-1:0]     r_data;
  logic              r_err;
  logic [7:0]        r_tcnt;
  logic [CHW-1:0]    w_pick_idx;
  logic              w_found;
  logic              w_settled;
  logic              w_wait_expired;

  rr_priority_pick #(.N(N_CH), .IW(CHW)) u_pick (
    .i_req   (i_req),
    .i_ptr   (r_ptr),
    .o_idx   (w_pick_idx),
    .o_found (w_found)
  );

  // r_cnt is reused: settle cycles in SETTLE, waited cycles in WAIT.
  assign w_settled      = (r_cnt == 8'(SETTLE - 1));
  assign w_wait_expired = (r_cnt == 8'(TIMEOUT - 1));

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:   if (i_en && w_found) w_next_state = S_SETTLE;
      S_SETTLE: if (w_settled) w_next_state = S_START;
      S_START:  w_next_state = S_WAIT;
      S_WAIT:   if (i_conv_done || w_wait_expired) w_next_state = S_EMIT;
      S_EMIT:   if (i_out_ready) w_next_state = S_IDLE;
      default:  w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      r_ptr   <= '0;
      r_ch    <= '0;
      r_grant <= '0;
      r_cnt   <= '0;
      r_data  <= '0;
      r_err   <= 1'b0;
      r_tcnt  <= '0;
    end else begin
      r_state <= w_next_state;
      case (r_state)
        S_IDLE: begin
          if (i_en && w_found) begin
            r_ch    <= w_pick_idx;
            r_grant <= N_CH'(1) << w_pick_idx;
            r_cnt   <= '0;
          end
        end
        S_SETTLE: r_cnt <= r_cnt + 8'd1;
        S_START:  r_cnt <= '0;
        S_WAIT: begin
          // A done arriving on the expiry cycle still counts as success.
          if (i_conv_done) begin
            r_data <= i_conv_data;
            r_err  <= 1'b0;
          end else if (w_wait_expired) begin
            r_data <= '0;
            r_err  <= 1'b1;
            if (r_tcnt != 8'hFF) r_tcnt <= r_tcnt + 8'd1;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        S_EMIT: begin
          if (i_out_ready) begin
            r_ptr   <= (r_ch == CHW'(N_CH - 1)) ? '0 : r_ch + CHW'(1);
            r_grant <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  // Collector handshake: o_out_valid stays high with data/ch/err frozen until a
  // cycle with i_out_ready high; that cycle is the transfer.
  assign o_grant       = r_grant;
  assign o_conv_ch     = r_ch;
  assign o_out_ch      = r_ch;
  assign o_conv_start  = (r_state == S_START);
  assign o_out_valid   = (r_state == S_EMIT);
  assign o_busy        = (r_state != S_IDLE);
  assign o_out_data    = r_data;
  assign o_out_err     = r_err;
  assign o_timeout_cnt = r_tcnt;
  assign o_state       = r_state;

endmodule

// File: tb/tb_energy_sample_scheduler.sv
// Directed bench for energy_sample_scheduler (N_CH=4, DW=8, SETTLE=2, TIMEOUT=15).
module tb_energy_sample_scheduler;
  import energy_sample_scheduler_pkg::*;

  logic       clk;
  logic       rst;
  logic       en;
  logic [3:0] req;
  logic [3:0] o_grant;
  logic [1:0] o_conv_ch;
  logic       o_conv_start;
  logic       conv_done;
  logic [7:0] conv_data;
  logic       o_out_valid;
  logic       out_ready;
  logic [7:0] o_out_data;
  logic [1:0] o_out_ch;
  logic       o_out_err;
  logic       o_busy;
  logic [7:0] o_timeout_cnt;
  logic [2:0] o_state;

  int   tests_run    = 0;
  int   tests_failed = 0;
  bit   auto_en      = 1'b0;
  bit   auto_pend    = 1'b0;
  logic [7:0] auto_data = '0;
  bit   onehot_bad   = 1'b0;

  energy_sample_scheduler #(.N_CH(4), .DW(8), .SETTLE(2), .TIMEOUT(15)) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_en          (en),
    .i_req         (req),
    .o_grant       (o_grant),
    .o_conv_ch     (o_conv_ch),
    .o_conv_start  (o_conv_start),
    .i_conv_done   (conv_done),
    .i_conv_data   (conv_data),
    .o_out_valid   (o_out_valid),
    .i_out_ready   (out_ready),
    .o_out_data    (o_out_data),
    .o_out_ch      (o_out_ch),
    .o_out_err     (o_out_err),
    .o_busy        (o_busy),
    .o_timeout_cnt (o_timeout_cnt),
    .o_state       (o_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One cycle; converter model answers one cycle after start with 0xC0 | ch.
  task automatic step();
    @(posedge clk);
    #1;
    if ($countones(o_grant) > 1) onehot_bad = 1'b1;
    if (auto_en) begin
      conv_done = auto_pend;
      if (auto_pend) conv_data = auto_data;
      auto_pend = o_conv_start;
      auto_data = 8'hC0 + 8'(o_conv_ch);
    end
  endtask

  task automatic apply_reset();
    rst = 1'b1; en = 1'b1; req = '0; conv_done = 1'b0; conv_data = '0;
    out_ready = 1'b1; auto_en = 1'b0; auto_pend = 1'b0;
    step(); step();
    rst = 1'b0;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (!o_out_valid && n < 60) begin
      step();
      n++;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1; en = 1'b0; req = '0; conv_done = 1'b0; conv_data = '0; out_ready = 1'b0;
    step();
    tests_run++;
    if ({o_grant, o_conv_ch, o_conv_start, o_out_valid, o_busy} !== 9'd0) begin
      tests_failed++;
      $display("FAIL reset_ctrl got grant=%b ch=%0d start=%b valid=%b busy=%b want all 0",
               o_grant, o_conv_ch, o_conv_start, o_out_valid, o_busy);
    end
    tests_run++;
    if ({o_out_data, o_out_ch, o_out_err, o_timeout_cnt, o_state} !== 22'd0) begin
      tests_failed++;
      $display("FAIL reset_data got data=%h och=%0d err=%b tcnt=%0d state=%0d want all 0",
               o_out_data, o_out_ch, o_out_err, o_timeout_cnt, o_state);
    end
    rst = 1'b0;
  endtask

  task automatic test_single();
    apply_reset();
    req = 4'b0100;             // cycle t
    step();                    // t+1
    tests_run++;
    if (o_grant !== 4'b0100 || o_conv_ch !== 2'd2) begin
      tests_failed++;
      $display("FAIL single_grant got grant=%b ch=%0d want 0100 ch=2", o_grant, o_conv_ch);
    end
    req = 4'b0000;
    step();                    // t+2
    tests_run++;
    if (o_conv_start !== 1'b0) begin
      tests_failed++;
      $display("FAIL single_early_start got %b want 0", o_conv_start);
    end
    step();                    // t+3
    tests_run++;
    if (o_conv_start !== 1'b1) begin
      tests_failed++;
      $display("FAIL single_start got %b want 1", o_conv_start);
    end
    step();                    // t+4
    conv_done = 1'b1; conv_data = 8'hA5;
    step();                    // t+5
    conv_done = 1'b0; conv_data = 8'h00;
    tests_run++;
    if (o_out_valid !== 1'b1 || o_out_data !== 8'hA5 || o_out_ch !== 2'd2 || o_out_err !== 1'b0) begin
      tests_failed++;
      $display("FAIL single_emit got v=%b d=%h ch=%0d err=%b want 1 a5 2 0",
               o_out_valid, o_out_data, o_out_ch, o_out_err);
    end
    step();                    // t+6
    step();                    // t+7
    tests_run++;
    if (o_busy !== 1'b0 || o_grant !== 4'b0000) begin
      tests_failed++;
      $display("FAIL single_idle got busy=%b grant=%b want 0 0000", o_busy, o_grant);
    end
  endtask

  task automatic test_round_robin();
    logic [1:0] exp_ch[5];
    int n;
    exp_ch = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    apply_reset();
    onehot_bad = 1'b0;
    auto_en = 1'b1;
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      wait_valid(n);
      tests_run++;
      if (o_out_valid !== 1'b1 || o_out_ch !== exp_ch[k] ||
          o_out_data !== (8'hC0 + 8'(exp_ch[k])) || o_out_err !== 1'b0) begin
        tests_failed++;
        $display("FAIL rr_seq%0d got v=%b ch=%0d d=%h err=%b want 1 %0d %h 0", k,
                 o_out_valid, o_out_ch, o_out_data, o_out_err, exp_ch[k], 8'hC0 + 8'(exp_ch[k]));
      end
      step();
    end
    tests_run++;
    if (onehot_bad !== 1'b0) begin
      tests_failed++;
      $display("FAIL rr_onehot got multi-hot grant seen=%b want 0", onehot_bad);
    end
    req = '0; auto_en = 1'b0; auto_pend = 1'b0; conv_done = 1'b0;
  endtask

  task automatic test_timeout();
    int n;
    bit lost;
    apply_reset();
    req = 4'b0001;
    wait_valid(n);
    tests_run++;
    if (o_out_valid !== 1'b1 || n != 19) begin
      tests_failed++;
      $display("FAIL to_latency got valid=%b cycles=%0d want 1 19", o_out_valid, n);
    end
    tests_run++;
    if (o_out_data !== 8'h00 || o_out_err !== 1'b1 || o_out_ch !== 2'd0 || o_timeout_cnt !== 8'd1) begin
      tests_failed++;
      $display("FAIL to_result got d=%h err=%b ch=%0d tcnt=%0d want 00 1 0 1",
               o_out_data, o_out_err, o_out_ch, o_timeout_cnt);
    end
    step();                    // handshake, IDLE picks again this cycle
    for (int i = 0; i < 18; i++) step();
    conv_done = 1'b1; conv_data = 8'h3C;   // last WAIT cycle
    step();
    conv_done = 1'b0;
    tests_run++;
    if (o_out_valid !== 1'b1 || o_out_err !== 1'b0 || o_out_data !== 8'h3C || o_timeout_cnt !== 8'd1) begin
      tests_failed++;
      $display("FAIL to_edge_done got v=%b err=%b d=%h tcnt=%0d want 1 0 3c 1",
               o_out_valid, o_out_err, o_out_data, o_timeout_cnt);
    end
    lost = 1'b0;
    for (int i = 0; i < 299; i++) begin
      step();
      wait_valid(n);
      if (!o_out_valid) begin
        lost = 1'b1;
        break;
      end
    end
    tests_run++;
    if (lost || o_timeout_cnt !== 8'd255) begin
      tests_failed++;
      $display("FAIL to_saturate got tcnt=%0d stalled=%b want 255 0", o_timeout_cnt, lost);
    end
    step();
    req = '0;
  endtask

  task automatic test_back_pressure();
    int n;
    bit bad;
    logic [7:0] d;
    logic [1:0] c;
    apply_reset();
    out_ready = 1'b0;
    auto_en = 1'b1;
    req = 4'b0010;
    wait_valid(n);
    d = o_out_data; c = o_out_ch;
    tests_run++;
    if (o_out_valid !== 1'b1 || d !== 8'hC1 || c !== 2'd1) begin
      tests_failed++;
      $display("FAIL bp_first got v=%b d=%h ch=%0d want 1 c1 1", o_out_valid, d, c);
    end
    bad = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (o_out_valid !== 1'b1 || o_out_data !== d || o_out_ch !== c || o_conv_start !== 1'b0) bad = 1'b1;
    end
    tests_run++;
    if (bad) begin
      tests_failed++;
      $display("FAIL bp_hold got v=%b d=%h ch=%0d start=%b want held 1 %h %0d 0",
               o_out_valid, o_out_data, o_out_ch, o_conv_start, d, c);
    end
    out_ready = 1'b1;
    step();
    tests_run++;
    if (o_state !== S_IDLE || o_out_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL bp_release got state=%0d valid=%b want 0 0", o_state, o_out_valid);
    end
    req = '0; auto_en = 1'b0; auto_pend = 1'b0; conv_done = 1'b0;
  endtask

  task automatic test_disable_stray();
    int n;
    bit bad;
    apply_reset();
    req = 4'b1111;
    n = 0;
    while (o_state !== S_WAIT && n < 10) begin
      step();
      n++;
    end
    en = 1'b0;
    step(); step();
    conv_done = 1'b1; conv_data = 8'h5A;
    step();
    conv_done = 1'b0;
    tests_run++;
    if (o_out_valid !== 1'b1 || o_out_data !== 8'h5A || o_out_ch !== 2'd0 || o_out_err !== 1'b0) begin
      tests_failed++;
      $display("FAIL dis_complete got v=%b d=%h ch=%0d err=%b want 1 5a 0 0",
               o_out_valid, o_out_data, o_out_ch, o_out_err);
    end
    step();
    bad = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (o_grant !== 4'b0000 || o_busy !== 1'b0) bad = 1'b1;
    end
    tests_run++;
    if (bad) begin
      tests_failed++;
      $display("FAIL dis_no_grant got grant=%b busy=%b want 0000 0", o_grant, o_busy);
    end
    req = '0;
    conv_done = 1'b1; conv_data = 8'h77;
    step();
    conv_done = 1'b0;
    bad = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (o_out_valid !== 1'b0 || o_state !== S_IDLE) bad = 1'b1;
    end
    tests_run++;
    if (bad || o_out_data !== 8'h5A) begin
      tests_failed++;
      $display("FAIL stray_done got v=%b state=%0d d=%h want 0 0 5a", o_out_valid, o_state, o_out_data);
    end
    en = 1'b1;
  endtask

  task automatic test_reset_mid_wait();
    int n;
    apply_reset();
    auto_en = 1'b1;
    req = 4'b0010;
    wait_valid(n);
    step();                    // handshake: pointer now 2
    auto_en = 1'b0; auto_pend = 1'b0; conv_done = 1'b0;
    req = 4'b0100;
    n = 0;
    while (o_state !== S_WAIT && n < 10) begin
      step();
      n++;
    end
    tests_run++;
    if (o_state !== S_WAIT || o_grant !== 4'b0100) begin
      tests_failed++;
      $display("FAIL rst_setup got state=%0d grant=%b want 3 0100", o_state, o_grant);
    end
    rst = 1'b1;
    #1;
    tests_run++;
    if ({o_grant, o_conv_ch, o_conv_start, o_out_valid, o_busy, o_out_data, o_out_err, o_state} !== 22'd0) begin
      tests_failed++;
      $display("FAIL rst_async got grant=%b ch=%0d start=%b v=%b busy=%b d=%h err=%b state=%0d want all 0",
               o_grant, o_conv_ch, o_conv_start, o_out_valid, o_busy, o_out_data, o_out_err, o_state);
    end
    step();
    rst = 1'b0;
    req = 4'b1111;
    step();
    tests_run++;
    if (o_grant !== 4'b0001 || o_conv_ch !== 2'd0) begin
      tests_failed++;
      $display("FAIL rst_ptr got grant=%b ch=%0d want 0001 0", o_grant, o_conv_ch);
    end
    req = '0;
  endtask

  // ---------------- sequence / report ----------------
  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_timeout();
    test_back_pressure();
    test_disable_stray();
    test_reset_mid_wait();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
